crtc_dma_arbiter: RTL and testbench
===================================

Name: crtc_dma_arbiter

Overview:
- Sits directly upstream of the CRTC text-row DMA.
- Arbitrates the shared 17-bit main-RAM port between the Z80 CPU and the CRTC row fetch: converts the CRTC `busreq` into a Z80 BUSRQ/BUSAK handshake and returns `busack` to the CRTC.
- While granted, steers the RAM address/strobes to the CRTC's `ram_adr` and blocks CPU writes.
- Counts bus-stolen cycles per frame and flags a stalled handshake for debug.

Parameters:
- GUARD_CYC, 2, idle cycles after BUSAK release before a new request may be raised (1..15)
- TIMEOUT_CYC, 1023, cycles in REQ without BUSAK before `timeout_err` sets (10-bit)
- CNT_W, 16, width of stolen-cycle counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dma_req  in  1  CRTC busreq (level; high for whole row fetch)
- dma_ack  out  1  CRTC busack; high only while bus granted
- dma_adr  in  17  CRTC ram_adr
- cpu_adr  in  17  CPU physical RAM address (bank bit included)
- cpu_rd  in  1  CPU memory read strobe, active-high
- cpu_wr  in  1  CPU memory write strobe, active-high
- cpu_busrq_n  out  1  to Z80 BUSRQ_n
- cpu_busak_n  in  1  from Z80 BUSAK_n
- ram_adr  out  17  RAM address
- ram_oe  out  1  RAM read enable
- ram_we  out  1  RAM write enable
- vsync  in  1  CRTC vsync (frame marker)
- steal_cnt  out  CNT_W  stolen cycles in previous frame
- timeout_err  out  1  sticky handshake-stall flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, dma_ack=0, cpu_busrq_n=1, steal_cnt=0, timeout_err=0, all counters 0.
  - During reset ram_adr=cpu_adr, ram_oe=cpu_rd, ram_we=cpu_wr (mux follows the ungranted path).
- FSM states IDLE, REQ, GRANT, RELEASE, GUARD; all transitions registered on posedge clk.
  - IDLE: dma_req=1 → REQ; cpu_busrq_n goes low the same edge.
  - REQ: cpu_busrq_n=0. When cpu_busak_n=0 is sampled → GRANT, dma_ack=1 from that edge. Latency from dma_req rise to dma_ack rise is ≥2 clocks (1 + Z80 BUSAK delay).
  - REQ, dma_req drops before grant: → IDLE, cpu_busrq_n=1 next edge, no ack issued.
  - GRANT: dma_ack=1, cpu_busrq_n=0. dma_req=0 → RELEASE; dma_ack and busrq_n deassert the same edge.
  - RELEASE: wait for cpu_busak_n=1 → GUARD, load guard counter with GUARD_CYC-1.
  - GUARD: count down to 0 → IDLE. A dma_req arriving during GUARD is held (level) and served from IDLE.
- Bus mux (combinational):
  - state==GRANT: ram_adr=dma_adr, ram_oe=1, ram_we=0.
  - Otherwise: ram_adr=cpu_adr, ram_oe=cpu_rd, ram_we=cpu_wr.
  - A cpu_wr asserted while in GRANT is a protocol violation; it must never reach ram_we.
- Timeout:
  - 10-bit counter increments each cycle in REQ and clears on leaving REQ.
  - Reaching TIMEOUT_CYC sets timeout_err. The request stays asserted (no abort).
  - err_clr clears the flag; if the set condition coincides with err_clr on the same edge, set wins.
- Steal counter:
  - Accumulator increments each GRANT cycle and saturates at all-ones.
  - On the vsync rising edge (detected against a registered vsync), steal_cnt ← accumulator (including the current cycle if GRANT) and the accumulator ← 0.
- Unexpected busak: cpu_busak_n=0 while IDLE or GUARD is ignored; no ack is issued.

Decomposition:
- Shared package (crtc_pkg): FSM state enum; the constant 17-bit RAM address width; default GUARD_CYC and TIMEOUT_CYC.
- One natural sub-module: `frame_steal_counter` (edge-detect, saturating accumulate, snapshot). The FSM and mux stay in the top level.

Test Plan:
- Basic grant: dma_req↑ at t0, model busak_n low 3 clocks after busrq_n low → dma_ack↑ 1 clock after busak seen; ram_adr=dma_adr=0x0F300 while granted; ram_we=0.
- Release/guard: dma_req↓ → dma_ack and busrq_n deassert next edge; busak_n↑ 2 clocks later; a new dma_req held throughout → busrq_n low again only after GUARD_CYC=2 idle cycles.
- Abort in REQ: dma_req pulse of 1 cycle with busak never asserted → busrq_n back to 1, dma_ack stays 0, FSM IDLE.
- Timeout: busak_n stuck high → timeout_err=1 exactly at cycle 1023 in REQ; err_clr pulse while still stalled → flag re-sets; err_clr after grant → 0.
- Steal count: 25 row fetches of 240 grant cycles in a frame, then vsync↑ → steal_cnt=6000; second frame with no DMA → 0.
- Reset mid-GRANT: reset_n low asynchronously → dma_ack=0 and busrq_n=1 immediately (no clock), ram mux on CPU path, steal_cnt=0.

Source files
------------

// File: rtl/crtc_pkg.sv
// crtc_pkg - shared types and constants for the CRTC DMA / Z80 bus arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   RAM_AW          : main-RAM address width (bank bit included)
//   GUARD_CYC_DEF   : default idle cycles after BUSAK release
//   TIMEOUT_CYC_DEF : default REQ cycles before a handshake stall is flagged
//   TMO_W           : width of the handshake-stall timer
package crtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GUARD   = 3'd4
  } arb_state_e;

  localparam int RAM_AW          = 17;
  localparam int GUARD_CYC_DEF   = 2;
  localparam int TIMEOUT_CYC_DEF = 1023;
  localparam int TMO_W           = 10;

endpackage

// File: rtl/frame_steal_counter.sv
// frame_steal_counter - counts bus-stolen (granted) cycles per frame.
//   clk, reset_n : clock, async active-low reset
//   grant        : high for every cycle the CRTC owns the RAM port
//   vsync        : CRTC vsync; its rising edge closes the frame
//   steal_cnt    : granted cycles counted in the previous frame (saturating)
module frame_steal_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             grant,
  input  logic             vsync,
  output logic [CNT_W-1:0] steal_cnt
);

  logic             vsync_q;
  logic             vsync_rise;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] acc_inc;

  assign vsync_rise = vsync & ~vsync_q;
  // The snapshot includes the current cycle, so it takes the incremented value.
  assign acc_inc    = (grant && (acc_q != {CNT_W{1'b1}})) ? acc_q + 1'b1 : acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q   <= 1'b0;
      acc_q     <= '0;
      steal_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync_rise) begin
        steal_cnt <= acc_inc;
        acc_q     <= '0;
      end else begin
        acc_q <= acc_inc;
      end
    end
  end

endmodule

// File: rtl/crtc_dma_arbiter.sv
// crtc_dma_arbiter - hands the shared main-RAM port between the Z80 and the
// CRTC row DMA using the Z80 BUSRQ/BUSAK handshake.
//   clk, reset_n          : clock, async active-low reset
//   dma_req / dma_ack     : CRTC busreq (level) / busack (granted)
//   dma_adr               : CRTC row-fetch address
//   cpu_adr/cpu_rd/cpu_wr : CPU RAM address and strobes
//   cpu_busrq_n/busak_n   : Z80 bus request / acknowledge
//   ram_adr/ram_oe/ram_we : muxed RAM port
//   vsync, steal_cnt      : frame marker, granted cycles of previous frame
//   timeout_err, err_clr  : sticky handshake-stall flag and its clear
//
// state   | meaning
// IDLE    | CPU owns RAM, no request pending
// REQ     | BUSRQ asserted, waiting for BUSAK
// GRANT   | CRTC owns RAM, dma_ack high
// RELEASE | BUSRQ dropped, waiting for BUSAK to go away
// GUARD   | CPU gets GUARD_CYC cycles before a new request
module crtc_dma_arbiter
  import crtc_pkg::*;
#(
  parameter int GUARD_CYC   = GUARD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_req,
  output logic              dma_ack,
  input  logic [RAM_AW-1:0] dma_adr,
  input  logic [RAM_AW-1:0] cpu_adr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic              cpu_busrq_n,
  input  logic              cpu_busak_n,
  output logic [RAM_AW-1:0] ram_adr,
  output logic              ram_oe,
  output logic              ram_we,
  input  logic              vsync,
  output logic [CNT_W-1:0]  steal_cnt,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam logic [3:0]       GUARD_LOAD = 4'(GUARD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_q, state_d;
  logic [3:0]       guard_q;
  logic [TMO_W-1:0] tmo_q;
  logic             grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // BUSAK seen in IDLE or GUARD is not ours and is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (dma_req) state_d = ST_REQ;
      ST_REQ: begin
        if (!dma_req)         state_d = ST_IDLE;
        else if (!cpu_busak_n) state_d = ST_GRANT;
      end
      ST_GRANT:   if (!dma_req) state_d = ST_RELEASE;
      ST_RELEASE: if (cpu_busak_n) state_d = ST_GUARD;
      ST_GUARD:   if (guard_q == 4'd0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant       = (state_q == ST_GRANT);
    dma_ack     = grant;
    cpu_busrq_n = !((state_q == ST_REQ) || (state_q == ST_GRANT));
    // CPU writes are gated during GRANT so a misbehaving CPU cannot corrupt RAM.
    ram_adr     = grant ? dma_adr : cpu_adr;
    ram_oe      = grant ? 1'b1    : cpu_rd;
    ram_we      = grant ? 1'b0    : cpu_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_q <= '0;
    end else if (state_q == ST_RELEASE && cpu_busak_n) begin
      guard_q <= GUARD_LOAD;
    end else if (state_q == ST_GUARD && guard_q != 4'd0) begin
      guard_q <= guard_q - 4'd1;
    end
  end

  // Timer holds at TIMEOUT_CYC so a stall keeps re-asserting the flag
  // even after err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_REQ) begin
      if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (state_q == ST_REQ && tmo_q >= TMO_LAST) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

  frame_steal_counter #(.CNT_W(CNT_W)) u_steal (
    .clk       (clk),
    .reset_n   (reset_n),
    .grant     (grant),
    .vsync     (vsync),
    .steal_cnt (steal_cnt)
  );

endmodule

// File: tb/tb_crtc_dma_arbiter.sv
// Directed bench for crtc_dma_arbiter; the Z80 BUSAK response is driven
// step by step from the stimulus sequence.
module tb_crtc_dma_arbiter;

  logic        clk;
  logic        reset_n;
  logic        dma_req;
  logic        dma_ack;
  logic [16:0] dma_adr;
  logic [16:0] cpu_adr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [16:0] ram_adr;
  logic        ram_oe;
  logic        ram_we;
  logic        vsync;
  logic [15:0] steal_cnt;
  logic        timeout_err;
  logic        err_clr;

  int n_assert = 0;
  int n_fail   = 0;

  crtc_dma_arbiter #(.GUARD_CYC(2), .TIMEOUT_CYC(1023), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dma_req     (dma_req),
    .dma_ack     (dma_ack),
    .dma_adr     (dma_adr),
    .cpu_adr     (cpu_adr),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_busrq_n (cpu_busrq_n),
    .cpu_busak_n (cpu_busak_n),
    .ram_adr     (ram_adr),
    .ram_oe      (ram_oe),
    .ram_we      (ram_we),
    .vsync       (vsync),
    .steal_cnt   (steal_cnt),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One row fetch with exactly n GRANT cycles; returns to IDLE.
  task automatic fetch(input int n);
    dma_req = 1'b1;
    tick;                       // REQ
    tick;
    tick;
    cpu_busak_n = 1'b0;
    tick;                       // GRANT
    repeat (n - 1) tick;
    dma_req = 1'b0;
    tick;                       // RELEASE
    tick;
    cpu_busak_n = 1'b1;
    tick;                       // GUARD
    tick;
    tick;                       // IDLE
  endtask

  initial begin
    reset_n     = 1'b0;
    dma_req     = 1'b0;
    dma_adr     = 17'h0F300;
    cpu_adr     = 17'h12345;
    cpu_rd      = 1'b1;
    cpu_wr      = 1'b0;
    cpu_busak_n = 1'b1;
    vsync       = 1'b0;
    err_clr     = 1'b0;

    // Reset state; mux follows CPU path
    #1;
    chk("rst_ack",     dma_ack, 0);
    chk("rst_busrq",   cpu_busrq_n, 1);
    chk("rst_steal",   steal_cnt, 0);
    chk("rst_err",     timeout_err, 0);
    chk("rst_ram_adr", ram_adr, 32'h12345);
    chk("rst_ram_oe",  ram_oe, 1);
    cpu_wr = 1'b1;
    #1;
    chk("rst_ram_we",  ram_we, 1);
    cpu_wr = 1'b0;
    #12;
    reset_n = 1'b1;
    tick;

    // Basic grant
    dma_req = 1'b1;
    chk("bg_ack_pre", dma_ack, 0);
    tick;
    chk("bg_busrq_low", cpu_busrq_n, 0);
    chk("bg_ack_req", dma_ack, 0);
    tick;
    tick;
    cpu_busak_n = 1'b0;
    chk("bg_ack_wait", dma_ack, 0);
    tick;
    chk("bg_ack_high", dma_ack, 1);
    chk("bg_busrq_grant", cpu_busrq_n, 0);
    cpu_wr  = 1'b1;
    cpu_adr = 17'h10000;
    #1;
    chk("bg_ram_adr", ram_adr, 32'h0F300);
    chk("bg_ram_oe",  ram_oe, 1);
    chk("bg_ram_we_blocked", ram_we, 0);
    tick;
    chk("bg_ack_hold", dma_ack, 1);

    // Release and guard
    dma_req = 1'b0;
    tick;
    chk("rl_ack", dma_ack, 0);
    chk("rl_busrq", cpu_busrq_n, 1);
    chk("rl_ram_adr", ram_adr, 32'h10000);
    chk("rl_ram_we", ram_we, 1);
    cpu_wr = 1'b0;
    tick;
    tick;
    cpu_busak_n = 1'b1;
    tick;                       // GUARD
    dma_req = 1'b1;
    chk("gd_busrq0", cpu_busrq_n, 1);
    tick;
    chk("gd_busrq1", cpu_busrq_n, 1);
    tick;                       // IDLE
    chk("gd_busrq_idle", cpu_busrq_n, 1);
    tick;                       // REQ
    chk("gd_busrq_req", cpu_busrq_n, 0);
    dma_req = 1'b0;
    tick;
    chk("gd_drop_busrq", cpu_busrq_n, 1);

    // One-cycle abort in REQ
    dma_req = 1'b1;
    tick;
    chk("ab_busrq_low", cpu_busrq_n, 0);
    dma_req = 1'b0;
    tick;
    chk("ab_busrq_high", cpu_busrq_n, 1);
    chk("ab_ack", dma_ack, 0);
    tick;
    chk("ab_idle_busrq", cpu_busrq_n, 1);
    chk("ab_idle_ack", dma_ack, 0);

    // Unexpected busak while IDLE
    cpu_busak_n = 1'b0;
    tick;
    tick;
    chk("ub_ack", dma_ack, 0);
    chk("ub_busrq", cpu_busrq_n, 1);
    cpu_busak_n = 1'b1;
    tick;

    // Timeout
    dma_req = 1'b1;
    tick;                       // REQ, first cycle
    repeat (1022) tick;
    chk("to_err_1022", timeout_err, 0);
    tick;
    chk("to_err_1023", timeout_err, 1);
    err_clr = 1'b1;
    tick;
    chk("to_clr_stalled", timeout_err, 1);
    err_clr = 1'b0;
    tick;
    chk("to_err_hold", timeout_err, 1);
    chk("to_busrq_held", cpu_busrq_n, 0);
    cpu_busak_n = 1'b0;
    tick;
    chk("to_ack", dma_ack, 1);
    chk("to_err_grant", timeout_err, 1);
    err_clr = 1'b1;
    tick;
    chk("to_clr_granted", timeout_err, 0);
    err_clr = 1'b0;
    dma_req = 1'b0;
    tick;
    cpu_busak_n = 1'b1;
    tick;
    tick;
    tick;

    // Steal counter: clear frame, 25 x 240 grants, then empty frame
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    tick;
    for (int r = 0; r < 25; r++) fetch(240);
    vsync = 1'b1;
    tick;
    chk("sc_frame1", steal_cnt, 6000);
    vsync = 1'b0;
    repeat (20) tick;
    vsync = 1'b1;
    tick;
    chk("sc_frame2", steal_cnt, 0);
    vsync = 1'b0;
    tick;
    fetch(5);
    vsync = 1'b1;
    tick;
    chk("sc_frame3", steal_cnt, 5);
    vsync = 1'b0;
    tick;

    // Asynchronous reset mid-GRANT
    dma_req = 1'b1;
    tick;
    tick;
    cpu_busak_n = 1'b0;
    tick;
    chk("mr_ack_pre", dma_ack, 1);
    cpu_adr = 17'h00ABC;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_ack", dma_ack, 0);
    chk("mr_busrq", cpu_busrq_n, 1);
    chk("mr_ram_adr", ram_adr, 32'h00ABC);
    chk("mr_ram_oe", ram_oe, 0);
    chk("mr_ram_we", ram_we, 1);
    chk("mr_steal", steal_cnt, 0);
    chk("mr_err", timeout_err, 0);
    dma_req     = 1'b0;
    cpu_busak_n = 1'b1;
    #20;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
